// File: rtl/proc_trace_buffer.sv
// Write-trace capture FIFO for the single-cycle MIPS core: time-stamps register and memory writes.
// Optional macro TRACE_ZERO_FILTER_EN discards register-0 writes before admission.
module proc_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  localparam int E_W   = 1 + CYC_W + ADDR_W + DATA_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              clear,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [E_W-1:0]    out_data,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam logic [LW:0] DEPTH_L = (LW+1)'(DEPTH);

  logic [E_W-1:0]    mem_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r, wr_ptr_r;
  logic [CYC_W-1:0]  cyc_r;

  logic              rf_keep_s, ev_rf_s, ev_dm_s, pop_s;
  logic              rf_push_s, dm_push_s;
  logic [LW:0]       free_s;
  logic [1:0]        n_push_s, n_drop_s;
  logic [PW-1:0]     rd_next_s, wr_next_s, dm_slot_s;
  logic [LW-1:0]     lvl_pop_s, level_next_s;
  logic [16:0]       dc_sum_s;
  logic [15:0]       dc_next_s;
  logic [E_W-1:0]    rf_entry_s, dm_entry_s, head_s;

`ifdef TRACE_ZERO_FILTER_EN
  assign rf_keep_s = (rf_waddr != 5'd0);
`else
  assign rf_keep_s = 1'b1;
`endif

  // Admission, pointer and next-head computation for this edge
  always_comb begin
    ev_rf_s    = capture_en & ~clear & rf_we & rf_keep_s;
    ev_dm_s    = capture_en & ~clear & dm_we;
    pop_s      = out_valid & out_ready & ~clear;
    free_s     = DEPTH_L - {1'b0, level} + {{LW{1'b0}}, pop_s};
    rf_push_s  = ev_rf_s & (free_s >= (LW+1)'(1));
    dm_push_s  = ev_dm_s & (free_s >= (rf_push_s ? (LW+1)'(2) : (LW+1)'(1)));
    n_push_s   = {1'b0, rf_push_s} + {1'b0, dm_push_s};
    n_drop_s   = {1'b0, ev_rf_s} + {1'b0, ev_dm_s} - n_push_s;
    rd_next_s  = rd_ptr_r + PW'(pop_s);
    dm_slot_s  = wr_ptr_r + PW'(rf_push_s);
    wr_next_s  = wr_ptr_r + PW'(n_push_s);
    lvl_pop_s  = level - LW'(pop_s);
    level_next_s = lvl_pop_s + LW'(n_push_s);
    dc_sum_s   = {1'b0, drop_count} + {15'd0, n_drop_s};
    dc_next_s  = dc_sum_s[16] ? 16'hFFFF : dc_sum_s[15:0];
    rf_entry_s = {1'b0, cyc_r, ADDR_W'(rf_waddr), rf_wdata};
    dm_entry_s = {1'b1, cyc_r, dm_addr, dm_wdata};
    // The new head is an older stored entry unless the FIFO drains to only this edge's pushes
    if (lvl_pop_s != LW'(0)) begin
      head_s = mem_r[rd_next_s];
    end else if (rf_push_s) begin
      head_s = rf_entry_s;
    end else if (dm_push_s) begin
      head_s = dm_entry_s;
    end else begin
      head_s = '0;
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge clk) begin
    if (rf_push_s) begin
      mem_r[wr_ptr_r] <= rf_entry_s;
    end
    if (dm_push_s) begin
      mem_r[dm_slot_s] <= dm_entry_s;
    end
  end

  // Cycle counter, pointers, occupancy, registered head and drop statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_r      <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      cyc_r <= cyc_r + CYC_W'(1);
      if (clear) begin
        rd_ptr_r   <= '0;
        wr_ptr_r   <= '0;
        level      <= '0;
        out_valid  <= 1'b0;
        out_data   <= '0;
        overflow   <= 1'b0;
        drop_count <= 16'd0;
      end else begin
        rd_ptr_r  <= rd_next_s;
        wr_ptr_r  <= wr_next_s;
        level     <= level_next_s;
        out_valid <= (level_next_s != LW'(0));
        out_data  <= head_s;
        if (n_drop_s != 2'd0) begin
          overflow   <= 1'b1;
          drop_count <= dc_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Randomized self-checking bench for proc_trace_buffer against a queue-based trace model.
module tb_proc_trace_buffer;

  localparam int E_W = 57;
`ifdef TRACE_ZERO_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, capture_en, clear, rf_we, dm_we, out_ready, out_valid, overflow;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, dm_wdata;
  logic [7:0]  dm_addr;
  logic [E_W-1:0] out_data;
  logic [4:0]  level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [E_W-1:0] q[$];
  logic [15:0] m_cyc, m_dc;
  logic        m_ovf;

  proc_trace_buffer dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .clear(clear),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_or_drop(input logic [E_W-1:0] e);
    if (q.size() < 16) q.push_back(e);
    else begin
      m_ovf = 1'b1;
      if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk({tag, "_data"}, 64'(out_data), 64'(q[0]));
    chk({tag, "_level"}, 64'(level), 64'(q.size()));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_drops"}, 64'(drop_count), 64'(m_dc));
  endtask

  // One clock edge: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic ce, input logic clr, input logic rwe, input logic [4:0] ra,
                      input logic [31:0] rd, input logic dwe, input logic [7:0] da,
                      input logic [31:0] dd, input logic rdy, input string tag);
    bit do_pop;
    capture_en = ce; clear = clr; rf_we = rwe; rf_waddr = ra; rf_wdata = rd;
    dm_we = dwe; dm_addr = da; dm_wdata = dd; out_ready = rdy;
    do_pop = (q.size() != 0) && rdy && !clr;
    if (clr) begin
      q.delete(); m_ovf = 1'b0; m_dc = 16'd0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (ce && rwe && !(FILT && ra == 5'd0)) push_or_drop({1'b0, m_cyc, 3'b000, ra, rd});
      if (ce && dwe) push_or_drop({1'b1, m_cyc, da, dd});
    end
    m_cyc = m_cyc + 16'd1;
    @(posedge clk); #1;
    check_state(tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 8'd0, 32'd0, rdy, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
  endtask

  initial begin
    logic [E_W-1:0] first;
    reset = 1'b0; capture_en = 1'b0; clear = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0;
    rf_wdata = 32'd0; dm_we = 1'b0; dm_addr = 8'd0; dm_wdata = 32'd0; out_ready = 1'b0;
    q.delete(); m_cyc = 16'd0; m_dc = 16'd0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // single event at stamp 3
    idle(1'b0, "idle0"); idle(1'b0, "idle1"); idle(1'b0, "idle2");
    step(1'b1, 1'b0, 1'b1, 5'd8, 32'h5, 1'b0, 8'd0, 32'd0, 1'b0, "single");
    chk("single_entry", 64'(out_data), 64'({1'b0, 16'd3, 8'd8, 32'h5}));

    // dual event ordering
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b0, "clr0");
    step(1'b1, 1'b0, 1'b1, 5'd9, 32'h77, 1'b1, 8'h10, 32'hA, 1'b0, "dual");
    first = out_data;
    idle(1'b1, "dual_pop");
    chk("dual_kind", 64'({first[56], out_data[56]}), 64'd1);
    chk("dual_stamp", 64'(out_data[55:40]), 64'(first[55:40]));
    idle(1'b1, "dual_drain");

    // overflow
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b0, 1'b1, 5'(i + 1), $urandom, 1'b0, 8'd0, 32'd0, 1'b0, "fill");
    step(1'b1, 1'b0, 1'b1, 5'd3, $urandom, 1'b1, 8'h20, $urandom, 1'b0, "ovf1");
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_dc1", 64'(drop_count), 64'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 5'd4, $urandom, 1'b1, 8'h21, $urandom, 1'b0, "ovf3");
    chk("ovf_dc7", 64'(drop_count), 64'd7);
    step(1'b1, 1'b0, 1'b1, 5'd5, $urandom, 1'b0, 8'd0, 32'd0, 1'b1, "full_pop");
    chk("full_pop_level", 64'(level), 64'd16);
    chk("full_pop_dc", 64'(drop_count), 64'd7);

    // clear with entries queued and a strobe active
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b0, "clr1");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, 5'd6, $urandom, 1'b0, 8'd0, 32'd0, 1'b0, "five");
    step(1'b1, 1'b1, 1'b1, 5'd7, 32'h1, 1'b1, 8'h1, 32'h2, 1'b1, "clr_strobe");
    check_reset_outputs("clr_out");

    // reset between edges
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 5'd2, $urandom, 1'b1, 8'h3, $urandom, 1'b0, "pre_rst");
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q.delete(); m_cyc = 16'd0; m_dc = 16'd0; m_ovf = 1'b0;
    #2 reset = 1'b1;

    // register-0 filter
    step(1'b1, 1'b0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 8'd0, 32'd0, 1'b0, "zero");
    chk("zero_level", 64'(level), FILT ? 64'd0 : 64'd1);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'h1, 1'b0, 8'd0, 32'd0, 1'b0, "stamp_after_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0), $urandom_range(0, 1),
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom_range(0, 1),
           8'($urandom), $urandom, ($urandom_range(0, 9) < (i % 200 < 100 ? 3 : 8)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
